risc_cpu_core: RTL
==================

Name: risc_cpu_core

Overview:
- Parametrised accumulator RISC core with a 3-bit opcode and an ADDR_WIDTH-bit operand address.
- Talks to a single shared instruction/data memory over a req/ready handshake, so memory may insert wait states.
- Adds a carry flag, single-step mode, resume-from-halt, and a retired-instruction counter.
- Sits between the top-level CPU wrapper and the memory model/arbiter.

Parameters:
- ADDR_WIDTH, 5, operand/PC address width; data/instruction width DW = ADDR_WIDTH+3.
- RESET_PC, 0, PC value loaded on reset.
- CNT_WIDTH, 16, width of retired-instruction counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- go  input  1  resume from HALTED or STEP_WAIT; sampled on rising edge.
- step_mode  input  1  1 = stop in STEP_WAIT after each retired instruction.
- mem_req  output  1  memory access request.
- mem_we  output  1  1 = write, valid with mem_req.
- mem_addr  output  ADDR_WIDTH  access address.
- mem_wdata  output  DW  write data (= acc).
- mem_rdata  input  DW  read data, valid in the mem_ready cycle.
- mem_ready  input  1  access completes this cycle; ignored when mem_req=0.
- halt  output  1  high in HALTED.
- stepped  output  1  high in STEP_WAIT.
- pc  output  ADDR_WIDTH  program counter.
- ir  output  DW  instruction register.
- acc  output  DW  accumulator.
- zero  output  1  combinational acc==0.
- carry  output  1  carry out of last ADD.
- instr_count  output  CNT_WIDTH  retired instructions, saturating.

Behaviour:
- Opcodes (ir[DW-1:DW-3]), operand a = ir[ADDR_WIDTH-1:0]:
  - 000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 JMP.
- Reset (async):
  - state=FETCH; pc=RESET_PC; ir=0; acc=0; carry=0; instr_count=0.
  - Hence zero=1, halt=0, stepped=0.
  - mem_req/mem_we are decoded from state; on assertion of rst they follow state=FETCH (mem_req=1 read) after rst releases, and a write is never presented during reset.
  - Reset mid-access abandons the access; a write already accepted by memory is not rolled back.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc; held stable until mem_ready.
  - On mem_ready: ir<=mem_rdata, pc<=pc+1 (mod 2^ADDR_WIDTH), go to DECODE.
- DECODE (1 cycle, no memory access):
  - HLT -> HALTED; retires.
  - SKZ: if zero, pc<=pc+1 (wraps); retires.
  - JMP: pc<=a; retires.
  - ADD/AND/XOR/LDA -> MEM_RD.
  - STO -> MEM_WR.
- MEM_RD:
  - mem_req=1, mem_we=0, mem_addr=a.
  - On mem_ready:
    - ADD: {carry,acc}<=acc+rdata; the sum wraps modulo 2^DW.
    - AND: acc<=acc&rdata.
    - XOR: acc<=acc^rdata.
    - LDA: acc<=rdata.
  - carry is changed only by ADD.
  - Instruction retires.
- MEM_WR:
  - mem_req=1, mem_we=1, mem_addr=a, mem_wdata=acc, held until mem_ready.
  - Retires on mem_ready.
- Next state on retire (non-HLT): STEP_WAIT if step_mode else FETCH. step_mode is sampled at the retire edge.
- Retire: instr_count<=instr_count+1 unless all-ones (saturates); HLT counts.
- HALTED:
  - halt=1, no memory access.
  - go -> FETCH at current pc (already past the HLT), so execution resumes at the next word.
- STEP_WAIT:
  - stepped=1; go -> FETCH.
  - If step_mode is cleared while waiting, it still waits for go.
- go outside HALTED/STEP_WAIT is ignored.
- Timing with zero-wait memory (mem_ready tied high):
  - HLT/SKZ/JMP: 2 cycles.
  - ADD/AND/XOR/LDA/STO: 3 cycles.
  - Each wait state adds 1 cycle to the phase concerned.
- PC increments wrap at 2^ADDR_WIDTH-1 -> 0.

Test Plan:
- Defaults, zero-wait memory, program mem[0..3]=A0?LDA 20 (8'hB4), 8'h55, 8'hD6, 8'h00, mem[20]=5, mem[21]=3 -> halt rises 11 cycles after reset release, mem[22]=8'h08, acc=8, carry=0, instr_count=4, pc=4.
- Same program with mem_ready asserted only every 3rd requested cycle -> identical final state; mem_addr/mem_we/mem_wdata are stable throughout each pending request.
- mem[20]=8'hF0, mem[21]=8'h20, LDA/ADD/HLT -> acc=8'h10, carry=1; a following XOR leaves carry=1.
- SKZ with acc=0 skips the next word; with acc=1 it does not; JMP 31 places SKZ at 31 -> pc wraps to 0 (or 1 when skipping).
- step_mode=1 -> stepped after each instruction, no mem_req until a 1-cycle go, then 1 instruction runs. HLT followed by go resumes at HLT address+1.
- Reset asserted during a MEM_WR wait state -> mem_req drops immediately; after release the core refetches from RESET_PC with acc=0, instr_count=0.

Source files
------------

// File: rtl/risc_cpu_core.sv
// Accumulator RISC core: 3-bit opcode plus operand address, one shared memory behind a
// req/ready handshake. Adds a carry flag, single-step/resume control and a retired-instruction counter.
module risc_cpu_core #(
    parameter int ADDR_WIDTH = 5,
    parameter int RESET_PC   = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    go,
    input  logic                    step_mode,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [ADDR_WIDTH+2:0]   mem_wdata,
    input  logic [ADDR_WIDTH+2:0]   mem_rdata,
    input  logic                    mem_ready,
    output logic                    halt,
    output logic                    stepped,
    output logic [ADDR_WIDTH-1:0]   pc,
    output logic [ADDR_WIDTH+2:0]   ir,
    output logic [ADDR_WIDTH+2:0]   acc,
    output logic                    zero,
    output logic                    carry,
    output logic [CNT_WIDTH-1:0]    instr_count
);
    localparam int DW = ADDR_WIDTH + 3;
    localparam logic [ADDR_WIDTH-1:0] LP_RESET_PC = ADDR_WIDTH'(RESET_PC);

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_MEM_RD = 3'd2;
    localparam logic [2:0] ST_MEM_WR = 3'd3;
    localparam logic [2:0] ST_HALTED = 3'd4;
    localparam logic [2:0] ST_STEP   = 3'd5;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [DW-1:0]         r_ir;
    logic [DW-1:0]         r_acc;
    logic                  r_carry;
    logic [CNT_WIDTH-1:0]  r_cnt;

    logic [2:0]            w_op;
    logic [ADDR_WIDTH-1:0] w_a;
    logic                  w_zero;
    logic [DW:0]           w_sum;
    logic                  w_retire;
    logic [2:0]            w_after_retire;
    logic                  w_access;

    assign w_op           = r_ir[DW-1:DW-3];
    assign w_a            = r_ir[ADDR_WIDTH-1:0];
    assign w_zero         = (r_acc == '0);
    assign w_sum          = {1'b0, r_acc} + {1'b0, mem_rdata};
    assign w_after_retire = step_mode ? ST_STEP : ST_FETCH;

    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            ST_DECODE: w_retire = (w_op == OP_HLT) || (w_op == OP_SKZ) || (w_op == OP_JMP);
            ST_MEM_RD: w_retire = mem_ready;
            ST_MEM_WR: w_retire = mem_ready;
            default:   w_retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_pc    <= LP_RESET_PC;
            r_ir    <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (mem_ready) begin
                        r_ir    <= mem_rdata;
                        r_pc    <= r_pc + 1'b1;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    case (w_op)
                        OP_HLT: r_state <= ST_HALTED;
                        OP_SKZ: begin
                            if (w_zero) r_pc <= r_pc + 1'b1;
                            r_state <= w_after_retire;
                        end
                        OP_JMP: begin
                            r_pc    <= w_a;
                            r_state <= w_after_retire;
                        end
                        OP_STO:  r_state <= ST_MEM_WR;
                        default: r_state <= ST_MEM_RD;
                    endcase
                end
                ST_MEM_RD: begin
                    if (mem_ready) begin
                        case (w_op)
                            OP_ADD:  {r_carry, r_acc} <= w_sum;
                            OP_AND:  r_acc <= r_acc & mem_rdata;
                            OP_XOR:  r_acc <= r_acc ^ mem_rdata;
                            default: r_acc <= mem_rdata;
                        endcase
                        r_state <= w_after_retire;
                    end
                end
                ST_MEM_WR: begin
                    if (mem_ready) r_state <= w_after_retire;
                end
                ST_HALTED, ST_STEP: begin
                    if (go) r_state <= ST_FETCH;
                end
                default: r_state <= ST_FETCH;
            endcase
            if (w_retire && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
        end
    end

    // Requests are masked while rst is high so an abandoned write is never left on the bus.
    assign w_access    = (r_state == ST_FETCH) || (r_state == ST_MEM_RD) || (r_state == ST_MEM_WR);
    assign mem_req     = w_access && !rst;
    assign mem_we      = (r_state == ST_MEM_WR) && !rst;
    assign mem_addr    = (r_state == ST_FETCH) ? r_pc : w_a;
    assign mem_wdata   = r_acc;
    assign halt        = (r_state == ST_HALTED);
    assign stepped     = (r_state == ST_STEP);
    assign pc          = r_pc;
    assign ir          = r_ir;
    assign acc         = r_acc;
    assign zero        = w_zero;
    assign carry       = r_carry;
    assign instr_count = r_cnt;
endmodule
